// File: rtl/residue_writeback_packer_pkg.sv
// Shared widths, qi modulus table, FSM state encoding and the range-check helper
// for the residue write-back packer.
package residue_writeback_packer_pkg;

  localparam int WB_DATA_W     = 30;
  localparam int WB_ADDR_W     = 6;
  localparam int WB_IDX_W      = 3;
  localparam int WB_FIFO_DEPTH = 4;
  localparam int WB_MEM_AW     = WB_IDX_W + WB_ADDR_W - 1;
  localparam int WB_NUM_QI     = 6;

  localparam logic [WB_DATA_W-1:0] QI_TABLE [WB_NUM_QI] = '{
    30'h3FFC0001, 30'h3FFA8001, 30'h3FF60001,
    30'h3FF00001, 30'h3FEE0001, 30'h3FE90001
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_t;

  // An index beyond the table is itself out of range.
  function automatic logic qi_out_of_range(input logic [WB_DATA_W-1:0] data,
                                           input logic [WB_IDX_W-1:0]  idx);
    logic oor;
    oor = 1'b1;
    for (int i = 0; i < WB_NUM_QI; i++) begin
      if (idx == WB_IDX_W'(i)) oor = (data >= QI_TABLE[i]);
    end
    return oor;
  endfunction

endpackage

// File: rtl/residue_writeback_packer_if.sv
// Residue stream from the reduction stage and the packed-word BRAM write port.
interface wb_res_if #(
  parameter int DATA_W = 30,
  parameter int ADDR_W = 6,
  parameter int IDX_W  = 3
);
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic              valid;
  logic              batch_done;

  modport master (output data, addr, idx, valid, batch_done);
  modport slave  (input  data, addr, idx, valid, batch_done);
endinterface

interface wb_mem_if #(
  parameter int DATA_W = 30,
  parameter int MEM_AW = 8
);
  logic [2*DATA_W-1:0] wdata;
  logic [MEM_AW-1:0]   waddr;
  logic                we;
  logic                ready;

  modport master (output wdata, waddr, we, input  ready);
  modport slave  (input  wdata, waddr, we, output ready);
endinterface

// File: rtl/residue_writeback_packer_wb_fifo.sv
// Small synchronous FIFO for packed words; head is read straight from the
// storage registers so it is valid the cycle after the push.
module wb_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/residue_writeback_packer.sv
// Pairs even/odd residues into {odd,even} words, buffers them for the residue BRAM
// and flags completion. Define WB_RANGE_CHECK_EN for the qi range check (+1 cycle).
module residue_writeback_packer
  import residue_writeback_packer_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int IDX_W      = WB_IDX_W,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int MEM_AW     = WB_MEM_AW
) (
  input  logic     clk,
  input  logic     rst,
  wb_res_if.slave  res,
  wb_mem_if.master mem,
  output logic     wb_done,
  output logic     pair_err,
  output logic     ovf_err,
  output logic     range_err
);

  localparam int WORD_W = 2*DATA_W + MEM_AW;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic [IDX_W-1:0]  in_idx;

`ifdef WB_RANGE_CHECK_EN
  logic              stg_valid_reg;
  logic [DATA_W-1:0] stg_data_reg;
  logic [ADDR_W-1:0] stg_addr_reg;
  logic [IDX_W-1:0]  stg_idx_reg;
  logic              range_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_valid_reg <= 1'b0;
      stg_data_reg  <= '0;
      stg_addr_reg  <= '0;
      stg_idx_reg   <= '0;
      range_err_reg <= 1'b0;
    end else begin
      stg_valid_reg <= res.valid;
      stg_data_reg  <= res.data;
      stg_addr_reg  <= res.addr;
      stg_idx_reg   <= res.idx;
      if (res.valid && qi_out_of_range(res.data, res.idx)) range_err_reg <= 1'b1;
    end
  end

  assign in_valid  = stg_valid_reg;
  assign in_data   = stg_data_reg;
  assign in_addr   = stg_addr_reg;
  assign in_idx    = stg_idx_reg;
  assign range_err = range_err_reg;
`else
  assign in_valid  = res.valid;
  assign in_data   = res.data;
  assign in_addr   = res.addr;
  assign in_idx    = res.idx;
  assign range_err = 1'b0;
`endif

  logic              pair_valid_reg;
  logic [DATA_W-1:0] pair_data_reg;
  logic [ADDR_W-2:0] pair_hi_reg;
  logic [IDX_W-1:0]  pair_idx_reg;
  logic              push_valid_reg;
  logic [WORD_W-1:0] push_word_reg;
  logic              pair_err_reg;
  logic              ovf_err_reg;
  logic              wb_done_reg;
  wb_state_t         state_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_pop;
  logic              pair_match;
  logic              drain_idle;

  assign fifo_pop   = ~fifo_empty & mem.ready;
  assign mem.we     = ~fifo_empty;
  assign {mem.waddr, mem.wdata} = fifo_head;

  assign pair_match = pair_valid_reg && (pair_hi_reg == in_addr[ADDR_W-1:1]) &&
                      (pair_idx_reg == in_idx);
  // Nothing left upstream of the memory port except possibly a stranded even.
  assign drain_idle = (fifo_count == '0) && !push_valid_reg && !in_valid && !res.valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_valid_reg <= 1'b0;
      pair_data_reg  <= '0;
      pair_hi_reg    <= '0;
      pair_idx_reg   <= '0;
      push_valid_reg <= 1'b0;
      push_word_reg  <= '0;
      pair_err_reg   <= 1'b0;
      ovf_err_reg    <= 1'b0;
    end else begin
      push_valid_reg <= 1'b0;
      if (in_valid && !in_addr[0]) begin
        pair_valid_reg <= 1'b1;
        pair_data_reg  <= in_data;
        pair_hi_reg    <= in_addr[ADDR_W-1:1];
        pair_idx_reg   <= in_idx;
        if (pair_valid_reg) pair_err_reg <= 1'b1;
      end else if (in_valid) begin
        pair_valid_reg <= 1'b0;
        if (pair_match) begin
          push_valid_reg <= 1'b1;
          push_word_reg  <= {in_idx, in_addr[ADDR_W-1:1], in_data, pair_data_reg};
        end else begin
          pair_err_reg <= 1'b1;
        end
      end else if (state_reg == ST_DRAIN && drain_idle && pair_valid_reg) begin
        pair_valid_reg <= 1'b0;
        pair_err_reg   <= 1'b1;
      end
      if (push_valid_reg && fifo_full && !fifo_pop) ovf_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      wb_done_reg <= 1'b0;
    end else begin
      wb_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (res.batch_done)  state_reg <= ST_DRAIN;
          else if (res.valid)  state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (res.batch_done)  state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_idle && !pair_valid_reg) begin
            state_reg   <= ST_DONE;
            wb_done_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign wb_done  = wb_done_reg;
  assign pair_err = pair_err_reg;
  assign ovf_err  = ovf_err_reg;

  wb_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_valid_reg),
    .wdata (push_word_reg),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_residue_writeback_packer.sv
// Directed bench for residue_writeback_packer: pairing, stalls, overflow, drain/done,
// mid-batch reset and the optional range check.
module tb_residue_writeback_packer;
  import residue_writeback_packer_pkg::*;

`ifdef WB_RANGE_CHECK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  logic wb_done;
  logic pair_err;
  logic ovf_err;
  logic range_err;

  wb_res_if #(.DATA_W(30), .ADDR_W(6), .IDX_W(3)) rin();
  wb_mem_if #(.DATA_W(30), .MEM_AW(8))            mif();

  residue_writeback_packer dut (
    .clk       (clk),
    .rst       (rst),
    .res       (rin),
    .mem       (mif),
    .wb_done   (wb_done),
    .pair_err  (pair_err),
    .ovf_err   (ovf_err),
    .range_err (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           chk_cnt = 0;
  int           pass_cnt = 0;
  int           cyc = 0;
  int           last_acc_cyc = 0;
  int           wb_cyc = 0;
  int           wb_pulses = 0;
  logic         toggle_en = 1'b0;
  logic [67:0]  wq[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mif.we && mif.ready) begin
      wq.push_back({mif.waddr, mif.wdata});
      $display("[%0d] write addr=0x%0h data=0x%0h", cyc, mif.waddr, mif.wdata);
      last_acc_cyc = cyc;
    end
    if (wb_done) begin
      wb_pulses = wb_pulses + 1;
      wb_cyc    = cyc;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) mif.ready = ~mif.ready;
  endtask

  task automatic send(input logic [29:0] d, input logic [5:0] a, input logic [2:0] i);
    rin.data  = d;
    rin.addr  = a;
    rin.idx   = i;
    rin.valid = 1'b1;
    tick();
    rin.valid = 1'b0;
  endtask

  function automatic logic [67:0] word(input int k, input logic [2:0] i,
                                       input logic [29:0] d0, input logic [29:0] d1);
    logic [4:0] hi;
    hi = 5'(k);
    return {i, hi, d1, d0};
  endfunction

  task automatic send_pair(input int k, input logic [2:0] i,
                           input logic [29:0] d0, input logic [29:0] d1);
    send(d0, 6'(2*k), i);
    send(d1, 6'(2*k+1), i);
  endtask

  task automatic do_reset();
    toggle_en       = 1'b0;
    rin.valid       = 1'b0;
    rin.batch_done  = 1'b0;
    rst             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wq.delete();
    wb_pulses = 0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k;
    k = 0;
    while (wq.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (wb_pulses == 0 && k < budget) begin
      tick();
      k++;
    end
  endtask

  initial begin
    rst            = 1'b0;
    rin.data       = '0;
    rin.addr       = '0;
    rin.idx        = '0;
    rin.valid      = 1'b0;
    rin.batch_done = 1'b0;
    mif.ready      = 1'b0;

    // Reset state
    do_reset();
    check("rst_we",        mif.we,    1'b0);
    check("rst_wb_done",   wb_done,   1'b0);
    check("rst_pair_err",  pair_err,  1'b0);
    check("rst_ovf_err",   ovf_err,   1'b0);
    check("rst_range_err", range_err, 1'b0);

    // Single pair, stalled memory: latency and hold-until-accepted
    mif.ready = 1'b0;
    send(30'h1234567, 6'd0, 3'd2);
    send(30'h0ABCDEF, 6'd1, 3'd2);
    check("lat_early_we", mif.we, 1'b0);
    repeat (LAT) tick();
    check("lat_we", mif.we, 1'b1);
    check("pair_word", {mif.waddr, mif.wdata}, {8'h40, 30'h0ABCDEF, 30'h1234567});
    repeat (3) tick();
    check("hold_word", {mif.waddr, mif.wdata}, {8'h40, 30'h0ABCDEF, 30'h1234567});
    mif.ready = 1'b1;
    tick();
    mif.ready = 1'b0;
    check("pair_wr_cnt", wq.size(), 1);
    check("pair_wr_word", wq[0], {8'h40, 30'h0ABCDEF, 30'h1234567});
    check("pair_we_after", mif.we, 1'b0);

    // Mismatched odd address
    check("perr_before", pair_err, 1'b0);
    send(30'h0000111, 6'd0, 3'd2);
    send(30'h0000222, 6'd3, 3'd2);
    repeat (LAT + 3) tick();
    check("perr_set", pair_err, 1'b1);
    check("perr_no_write", wq.size(), 1);
    check("perr_we", mif.we, 1'b0);

    // Five pairs into a stalled 4-deep FIFO
    do_reset();
    mif.ready = 1'b0;
    for (int k = 0; k < 5; k++) send_pair(k, 3'd1, 30'(32'h100 + k), 30'(32'h200 + k));
    repeat (LAT + 1) tick();
    check("ovf_set", ovf_err, 1'b1);
    check("ovf_we", mif.we, 1'b1);
    mif.ready = 1'b1;
    wait_writes(4, 20);
    repeat (4) tick();
    mif.ready = 1'b0;
    check("ovf_wr_cnt", wq.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("ovf_word%0d", k), wq[k], word(k, 3'd1, 30'(32'h100 + k), 30'(32'h200 + k)));

    // Full FIFO with push and pop on the same edge
    do_reset();
    mif.ready = 1'b0;
    for (int k = 0; k < 4; k++) send_pair(k, 3'd3, 30'(32'h3000 + k), 30'(32'h4000 + k));
    repeat (2) tick();
    check("full_pre_ovf", ovf_err, 1'b0);
    send_pair(4, 3'd3, 30'h3004, 30'h4004);
    repeat (LAT - 1) tick();
    mif.ready = 1'b1;
    tick();
    mif.ready = 1'b0;
    check("pp_no_ovf", ovf_err, 1'b0);
    check("pp_wr_cnt", wq.size(), 1);
    check("pp_first", wq[0], word(0, 3'd3, 30'h3000, 30'h4000));
    mif.ready = 1'b1;
    wait_writes(5, 20);
    repeat (2) tick();
    check("pp_total", wq.size(), 5);
    for (int k = 1; k < 5; k++)
      check($sformatf("pp_word%0d", k), wq[k], word(k, 3'd3, 30'(32'h3000 + k), 30'(32'h4000 + k)));
    check("pp_ovf_end", ovf_err, 1'b0);

    // 32 pairs, toggling ready, then batch_done
    do_reset();
    mif.ready = 1'b1;
    toggle_en = 1'b1;
    for (int k = 0; k < 32; k++)
      send_pair(k, 3'd4, 30'(32'h0100000 + 3*k), 30'(32'h2000000 + 5*k));
    rin.batch_done = 1'b1;
    tick();
    rin.batch_done = 1'b0;
    wait_done(200);
    repeat (5) tick();
    toggle_en = 1'b0;
    check("batch_wr_cnt", wq.size(), 32);
    for (int k = 0; k < 32; k++)
      check($sformatf("batch_word%0d", k), wq[k],
            word(k, 3'd4, 30'(32'h0100000 + 3*k), 30'(32'h2000000 + 5*k)));
    check("batch_wb_pulses", wb_pulses, 1);
    check("batch_wb_timing", wb_cyc - last_acc_cyc, 2);
    check("batch_pair_err", pair_err, 1'b0);
    check("batch_ovf_err", ovf_err, 1'b0);

    // Reset while two words are queued
    do_reset();
    mif.ready = 1'b0;
    send_pair(0, 3'd5, 30'h0000AAA, 30'h0000BBB);
    send_pair(1, 3'd5, 30'h0000CCC, 30'h0000DDD);
    repeat (LAT + 1) tick();
    check("mid_pre_we", mif.we, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_async_we", mif.we, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mif.ready = 1'b1;
    repeat (10) tick();
    check("mid_no_write", wq.size(), 0);
    check("mid_no_done", wb_pulses, 0);
    send_pair(0, 3'd5, 30'h0000AAA, 30'h0000BBB);
    send_pair(1, 3'd5, 30'h0000CCC, 30'h0000DDD);
    rin.batch_done = 1'b1;
    tick();
    rin.batch_done = 1'b0;
    wait_done(50);
    repeat (3) tick();
    check("clean_wr_cnt", wq.size(), 2);
    check("clean_word1", wq[1], word(1, 3'd5, 30'h0000CCC, 30'h0000DDD));
    check("clean_wb_pulses", wb_pulses, 1);

    // Range check on a residue equal to its modulus
    do_reset();
    mif.ready = 1'b1;
`ifdef WB_RANGE_CHECK_EN
    send(QI_TABLE[0], 6'd0, 3'd0);
    send(30'd5, 6'd1, 3'd0);
    wait_writes(1, 20);
    check("range_err_set", range_err, 1'b1);
    check("range_word", wq[0], word(0, 3'd0, QI_TABLE[0], 30'd5));
`else
    send(30'h3FFFFFFF, 6'd0, 3'd0);
    send(30'd5, 6'd1, 3'd0);
    wait_writes(1, 20);
    check("range_err_off", range_err, 1'b0);
    check("range_word", wq[0], word(0, 3'd0, 30'h3FFFFFFF, 30'd5));
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
